// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: assembles big-endian words, writes them
// to consecutive addresses and releases the CPU once the checksum verifies.
module imem_loader #(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter logic        HOLD_AT_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  count;
  logic [7:0]  csum;
  logic [7:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_word;

  logic fire_c, start_ok_c, word_done_c, last_word_c;

  // Next-state and handshake decode
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    start_ok_c  = 1'b0;
    word_done_c = 1'b0;
    last_word_c = (word_idx == 8'(count - 8'd1));
    case (state)
      S_COUNT, S_DATA, S_CHECK: in_ready = 1'b1;
      default:                  in_ready = 1'b0;
    endcase
    fire_c = in_valid && in_ready;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_nxt  = S_COUNT;
        end
      end
      S_COUNT: begin
        if (fire_c) state_nxt = (in_data == 8'd0) ? S_CHECK : S_DATA;
      end
      S_DATA: begin
        if (fire_c && byte_idx == 2'd3) begin
          word_done_c = 1'b1;
          if (last_word_c) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (fire_c) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath, write port and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 32'd0;
      cpu_hold <= HOLD_AT_RESET;
      done     <= 1'b0;
      err      <= 1'b0;
      count    <= 8'd0;
      csum     <= 8'd0;
      word_idx <= 8'd0;
      byte_idx <= 2'd0;
      asm_word <= 24'd0;
    end else begin
      wr_en <= word_done_c;
      if (start_ok_c) begin
        done     <= 1'b0;
        err      <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (fire_c) begin
        case (state)
          S_COUNT: begin
            count    <= in_data;
            csum     <= in_data;
            word_idx <= 8'd0;
            byte_idx <= 2'd0;
          end
          S_DATA: begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            asm_word <= {asm_word[15:0], in_data};
            if (word_done_c) begin
              wr_data  <= {asm_word, in_data};
              wr_addr  <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(word_idx);
              word_idx <= word_idx + 8'd1;
            end
          end
          S_CHECK: begin
            if (in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
